aes_round_ctrl: RTL and testbench

Round-sequencing controller for the AES encryption datapath. It accepts a start request and steps through the initial AddRoundKey, NR-1 full rounds and the final round. For each cycle it produces the round index, the key-expansion round constant and per-stage enables. It sits downstream of the block-load logic, which raises `start` once plaintext and key are captured, and upstream of the cipher/key-expansion datapath and its output register, which consume its enables and `done`.

---
 rtl/aes_round_ctrl.sv | 117 +++++++++++
 tb/tb_aes_round_ctrl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/aes_round_ctrl.sv
// Round sequencer for an iterative AES-128/192/256 datapath: walks INIT,
// NR-1 full rounds and the final round, emitting round index, rcon and stage enables.
module aes_round_ctrl #(
  parameter int NR = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       hold,
  output logic       busy,
  output logic       load_en,
  output logic       round_en,
  output logic       mix_en,
  output logic [3:0] round,
  output logic [7:0] rcon,
  output logic       done,
  output logic [2:0] dbg_state
);

  // start is a request level sampled only in IDLE; hold is a level that freezes
  // sequencing in INIT/ROUND/FINAL. Neither has a ready/acknowledge: the block
  // signals acceptance by raising busy the cycle after start is sampled.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INIT  = 3'd1,
    S_ROUND = 3'd2,
    S_FINAL = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  localparam logic [3:0] LAST_FULL = 4'(NR - 1);

  state_e     state_q, state_d;
  logic [3:0] round_q, round_d;
  logic [7:0] rcon_q, rcon_d;

  function automatic logic [7:0] xtime(input logic [7:0] x);
    xtime = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      round_q <= 4'd0;
      rcon_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      rcon_q  <= rcon_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    round_d  = round_q;
    rcon_d   = rcon_q;
    busy     = 1'b0;
    load_en  = 1'b0;
    round_en = 1'b0;
    mix_en   = 1'b0;
    done     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_INIT;
          round_d = 4'd0;
          rcon_d  = 8'h00;
        end
      end
      S_INIT: begin
        busy = 1'b1;
        if (!hold) begin
          load_en = 1'b1;
          state_d = S_ROUND;
          round_d = 4'd1;
          rcon_d  = 8'h01;
        end
      end
      S_ROUND: begin
        busy = 1'b1;
        if (!hold) begin
          round_en = 1'b1;
          mix_en   = 1'b1;
          round_d  = round_q + 4'd1;
          rcon_d   = xtime(rcon_q);
          if (round_q == LAST_FULL) begin
            state_d = S_FINAL;
          end
        end
      end
      S_FINAL: begin
        busy = 1'b1;
        if (!hold) begin
          round_en = 1'b1;
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        // round/rcon stay visible alongside done, then clear so IDLE reads all-zero
        done    = 1'b1;
        state_d = S_IDLE;
        round_d = 4'd0;
        rcon_d  = 8'h00;
      end
      default: begin
        state_d = S_IDLE;
        round_d = 4'd0;
        rcon_d  = 8'h00;
      end
    endcase
  end

  assign round     = round_q;
  assign rcon      = rcon_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Bench for aes_round_ctrl: three instances (NR=10/12/14) checked every cycle
// against a block-position reference model, plus directed latency sequences.
module tb_aes_round_ctrl;

  localparam int NR_OF [3] = '{10, 12, 14};
  localparam logic [7:0] RCON_TAB [15] = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h08,
    8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36, 8'h6c, 8'hd8, 8'hab, 8'h4d};

  logic clk;
  logic reset;
  logic [2:0] start_v, hold_v;
  logic [2:0] busy_v, load_v, ren_v, mix_v, done_v;
  logic [2:0][3:0] round_v;
  logic [2:0][7:0] rcon_v;
  logic [2:0][2:0] dbg_v;

  aes_round_ctrl #(.NR(10)) u_nr10 (
    .clk(clk), .reset(reset), .start(start_v[0]), .hold(hold_v[0]),
    .busy(busy_v[0]), .load_en(load_v[0]), .round_en(ren_v[0]), .mix_en(mix_v[0]),
    .round(round_v[0]), .rcon(rcon_v[0]), .done(done_v[0]), .dbg_state(dbg_v[0]));
  aes_round_ctrl #(.NR(12)) u_nr12 (
    .clk(clk), .reset(reset), .start(start_v[1]), .hold(hold_v[1]),
    .busy(busy_v[1]), .load_en(load_v[1]), .round_en(ren_v[1]), .mix_en(mix_v[1]),
    .round(round_v[1]), .rcon(rcon_v[1]), .done(done_v[1]), .dbg_state(dbg_v[1]));
  aes_round_ctrl #(.NR(14)) u_nr14 (
    .clk(clk), .reset(reset), .start(start_v[2]), .hold(hold_v[2]),
    .busy(busy_v[2]), .load_en(load_v[2]), .round_en(ren_v[2]), .mix_en(mix_v[2]),
    .round(round_v[2]), .rcon(rcon_v[2]), .done(done_v[2]), .dbg_state(dbg_v[2]));

  // clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests;
  int n_fail;
  int cyc;
  int pos [3];          // -1 idle, 0 init, 1..NR round index, NR+1 done cycle
  logic [2:0] done_seen, load_seen;

  typedef struct {
    int inst;
    int h0;
    int hlen;
    int exp_done;
  } vec_t;
  vec_t vecs [7];

  // reference model: position of the block within its NR+2 active cycles
  function automatic logic [16:0] exp_vec(input int i, input logic h);
    int p;
    int nr;
    logic [16:0] v;
    p  = pos[i];
    nr = NR_OF[i];
    v  = '0;
    if (reset || p < 0) begin
      v = '0;
    end else if (p == 0) begin
      v = {1'b1, !h, 1'b0, 1'b0, 1'b0, 4'd0, 8'h00};
    end else if (p < nr) begin
      v = {1'b1, 1'b0, !h, !h, 1'b0, 4'(p), RCON_TAB[p]};
    end else if (p == nr) begin
      v = {1'b1, 1'b0, !h, 1'b0, 1'b0, 4'(nr), RCON_TAB[nr]};
    end else begin
      v = {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'(nr), RCON_TAB[nr]};
    end
    return v;
  endfunction

  task automatic model_step();
    for (int i = 0; i < 3; i++) begin
      if (reset) pos[i] = -1;
      else if (pos[i] < 0) begin
        if (start_v[i]) pos[i] = 0;
      end else if (pos[i] <= NR_OF[i]) begin
        if (!hold_v[i]) pos[i] = pos[i] + 1;
      end else pos[i] = -1;
    end
  endtask

  function automatic logic [16:0] act_vec(input int i);
    return {busy_v[i], load_v[i], ren_v[i], mix_v[i], done_v[i], round_v[i], rcon_v[i]};
  endfunction

  task automatic check_all();
    logic [16:0] e;
    logic [16:0] a;
    for (int i = 0; i < 3; i++) begin
      e = exp_vec(i, hold_v[i]);
      a = act_vec(i);
      n_tests++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL outs nr%0d cyc%0d act={busy,load,ren,mix,done,round,rcon}=%h exp=%h",
                 NR_OF[i], cyc, a, e);
      end
      done_seen[i] = done_v[i];
      load_seen[i] = load_v[i];
    end
  endtask

  task automatic tick();
    @(negedge clk);
    check_all();
    @(posedge clk);
    model_step();
    #1;
    cyc++;
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s act=%0d exp=%0d", name, act, exp);
    end
  endtask

  // start sampled at edge 0; cycle c is the interval ending at edge c
  task automatic run_vec(input int inst, input int h0, input int hlen, input int exp_done);
    int got;
    got = -1;
    start_v[inst] = 1'b1;
    tick();
    start_v[inst] = 1'b0;
    for (int c = 1; c <= 60 && got < 0; c++) begin
      hold_v[inst] = (c >= h0) && (c < h0 + hlen);
      tick();
      if (done_seen[inst]) got = c;
    end
    hold_v[inst] = 1'b0;
    check_int($sformatf("done_cycle nr%0d hold@%0d x%0d", NR_OF[inst], h0, hlen), got, exp_done);
  endtask

  initial begin
    logic [7:0] d_q[$];
    logic [7:0] l_q[$];
    logic [7:0] exp_q[$];
    n_tests = 0;
    n_fail  = 0;
    cyc     = 0;
    done_seen = '0;
    load_seen = '0;
    for (int i = 0; i < 3; i++) pos[i] = -1;

    vecs[0] = '{inst: 0, h0: 0,  hlen: 0, exp_done: 12};
    vecs[1] = '{inst: 0, h0: 6,  hlen: 3, exp_done: 15};
    vecs[2] = '{inst: 1, h0: 0,  hlen: 0, exp_done: 14};
    vecs[3] = '{inst: 2, h0: 0,  hlen: 0, exp_done: 16};
    vecs[4] = '{inst: 2, h0: 1,  hlen: 2, exp_done: 18};
    vecs[5] = '{inst: 1, h0: 13, hlen: 1, exp_done: 15};
    vecs[6] = '{inst: 0, h0: 11, hlen: 4, exp_done: 16};

    reset   = 1'b1;
    start_v = '0;
    hold_v  = '0;
    repeat (3) tick();
    reset = 1'b0;
    repeat (2) tick();

    for (int k = 0; k < 7; k++) begin
      run_vec(vecs[k].inst, vecs[k].h0, vecs[k].hlen, vecs[k].exp_done);
      repeat (2) tick();
    end

    // start and hold together in IDLE: start wins, hold then stalls INIT
    start_v[0] = 1'b1;
    hold_v[0]  = 1'b1;
    tick();
    start_v[0] = 1'b0;
    tick();
    hold_v[0] = 1'b0;
    repeat (14) tick();

    // start held high: one block per 13 cycles, no extra load_en
    start_v[0] = 1'b1;
    tick();
    for (int c = 1; c <= 40; c++) begin
      if (c == 27) start_v[0] = 1'b0;
      tick();
      if (done_seen[0]) d_q.push_back(8'(c));
      if (load_seen[0]) l_q.push_back(8'(c));
    end
    exp_q = '{8'd12, 8'd25, 8'd38};
    check_int("b2b done count", d_q.size(), exp_q.size());
    for (int j = 0; j < 3 && j < d_q.size(); j++)
      check_int($sformatf("b2b done[%0d]", j), d_q[j], exp_q[j]);
    exp_q = '{8'd1, 8'd14, 8'd27};
    check_int("b2b load count", l_q.size(), exp_q.size());
    for (int j = 0; j < 3 && j < l_q.size(); j++)
      check_int($sformatf("b2b load[%0d]", j), l_q[j], exp_q[j]);
    repeat (2) tick();

    // reset while round=7: outputs clear immediately, no done follows
    start_v[0] = 1'b1;
    tick();
    start_v[0] = 1'b0;
    repeat (7) tick();
    check_int("pre-reset round", int'(round_v[0]), 7);
    #2 reset = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) pos[i] = -1;
    check_int("async reset outs", int'(act_vec(0)), 0);
    tick();
    tick();
    reset = 1'b0;
    repeat (16) tick();
    run_vec(0, 0, 0, 12);

    // randomized traffic, checked cycle by cycle against the model
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < 3; i++) begin
        start_v[i] = ($urandom_range(0, 2) == 0);
        hold_v[i]  = ($urandom_range(0, 3) == 0);
      end
      tick();
    end
    start_v = '0;
    hold_v  = '0;
    repeat (20) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
